led_frame_scheduler: RTL and testbench
======================================

# led_frame_scheduler

Frame-rate controller between the pixel FIFO and the parallel string shifter. It releases exactly one frame of pixel data per frame-period tick, and only when a full frame is buffered. After each frame it enforces the LED latch/reset gap, counts completed and missed frames, and aborts a stalled frame with a watchdog. The shifter sees the FIFO fill level only through this block's gated count, so a frame starts only when the scheduler allows it.

## Interface
Parameters:
- FIFO_ADDR_WIDTH, 12, FIFO address width; count ports are FIFO_ADDR_WIDTH+1 bits
- FRAME_WORDS, 900, FIFO words per frame (4 strings x 150 LEDs x 3 bytes / 2)
- WATCHDOG_CYCLES, 65535, maximum idle cycles allowed in SHIFT
- DEFAULT_LATCH_TICKS, 6000, informational (300 us at 50 ns clock); not used by logic

Ports:
- clk  in  1  system clock (50 ns)
- reset  in  1  synchronous, active-high
- cfg_enable  in  1  scheduling enable
- cfg_frame_period  in  24  frame period in clk cycles; 0 = tick every cycle
- cfg_latch_ticks  in  16  latch gap in clk cycles after frame end; 0 = no gap
- fifo_full_count  in  FIFO_ADDR_WIDTH+1  true FIFO fill level
- fifo_read  in  1  read strobe from the shifter, one pulse per word
- string_active  in  1  shifter busy
- gated_full_count  out  FIFO_ADDR_WIDTH+1  fill level presented to the shifter
- frame_start  out  1  one-cycle pulse when a frame is released
- frame_count  out  16  completed frames, wraps
- underrun_count  out  16  missed ticks, saturates at 0xFFFF
- fault  out  1  one-cycle pulse on watchdog abort
- busy  out  1  high in RELEASE, SHIFT, LATCH

## Operation
- States: IDLE, WAIT, RELEASE, SHIFT, LATCH.
- Frame timer: 24-bit down-counter.
  - Held at cfg_frame_period while cfg_enable=0.
  - Otherwise decrements; when it is 1 (or period is 0) it reloads and asserts tick for one cycle.
  - Tick period is exactly cfg_frame_period cycles.
- pending flag: set by tick, cleared on WAIT->RELEASE, cleared while cfg_enable=0.
  - tick while pending is already set: underrun_count += 1, saturating. pending stays set.
  - An underrun can occur in any state.
- IDLE -> WAIT when cfg_enable=1.
- WAIT -> IDLE when cfg_enable=0.
- WAIT -> RELEASE when pending=1 and fifo_full_count >= FRAME_WORDS. Same cycle: frame_start=1, read counter cleared.
- RELEASE -> SHIFT on the first fifo_read=1.
- SHIFT:
  - Count fifo_read pulses (11-bit counter, saturating at FRAME_WORDS).
  - -> LATCH when count == FRAME_WORDS and string_active=0. Same cycle: frame_count += 1, latch counter loaded with cfg_latch_ticks.
- LATCH: counter decrements to 0.
  - -> WAIT if cfg_enable=1; otherwise -> IDLE.
  - With cfg_latch_ticks=0, LATCH lasts exactly one cycle.
- Watchdog: counts cycles in RELEASE/SHIFT with fifo_read=0 and string_active=0; cleared on any activity.
  - On reaching WATCHDOG_CYCLES: fault=1 for one cycle, -> LATCH (full latch gap). frame_count is not incremented.
- cfg_enable deasserted in RELEASE/SHIFT/LATCH: the frame completes normally, then the block goes to IDLE.
- gated_full_count: equals fifo_full_count in RELEASE and SHIFT, otherwise 0.
- Reset mid-frame: all state and counters return to reset values immediately. The gated count drops to 0 on the next cycle, and the shifter drains whatever it has already queued.

## Timing
- Reset values: state IDLE; gated_full_count 0; frame_start 0; frame_count 0; underrun_count 0; fault 0; busy 0; timer = cfg_frame_period; pending 0.
- All outputs are registered.
- gated_full_count lags state and fifo_full_count by one cycle. It first shows a nonzero value the cycle after frame_start.
- busy rises in the same cycle as the gated count and falls on the cycle the state returns to WAIT/IDLE.
- Simultaneous events:
  - tick and WAIT->RELEASE in the same cycle: pending remains set for the next frame; no underrun.
  - fifo_read in the same cycle as the watchdog expiring: the read wins and the watchdog clears.
  - The underrun increment and the pending clear are evaluated from the pre-cycle pending value.
- fifo_read while not in RELEASE/SHIFT is ignored.

## Test plan
- Period 1000, latch 100, FIFO preloaded with 900 words, shifter model reads 900 words -> frame_start at cycle 1000; frame_count=1 after the last read plus string_active low; next release no earlier than the later of latch end and the next tick.
- Period 1000, FIFO holds 899 words for 3500 cycles -> no frame_start; underrun_count=2 (ticks 2 and 3); adding 1 word releases the frame immediately.
- FIFO holds 1350 words (1.5 frames) -> exactly one frame released; gated_full_count=0 from LATCH onward; no second frame until a tick and >=900 words.
- Shifter stalls after 10 reads -> fault pulse after exactly WATCHDOG_CYCLES idle cycles; LATCH follows; frame_count unchanged.
- cfg_enable dropped mid-SHIFT -> frame completes and frame_count increments; state goes to IDLE, busy=0, timer held.
- reset asserted mid-SHIFT -> the following cycle all outputs equal their reset values; gated_full_count=0.

Source files
------------

// File: rtl/led_frame_scheduler.sv
// Frame-rate scheduler between the pixel FIFO and the string shifter: releases one buffered
// frame per period tick, enforces the latch gap, counts frames/underruns, aborts stalled frames.
module led_frame_scheduler #(
    parameter int FIFO_ADDR_WIDTH     = 12,
    parameter int FRAME_WORDS         = 900,
    parameter int WATCHDOG_CYCLES     = 65535,
    parameter int DEFAULT_LATCH_TICKS = 6000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cfg_enable,
    input  logic [23:0]                cfg_frame_period,
    input  logic [15:0]                cfg_latch_ticks,
    input  logic [FIFO_ADDR_WIDTH:0]   fifo_full_count,
    input  logic                       fifo_read,
    input  logic                       string_active,
    output logic [FIFO_ADDR_WIDTH:0]   gated_full_count,
    output logic                       frame_start,
    output logic [15:0]                frame_count,
    output logic [15:0]                underrun_count,
    output logic                       fault,
    output logic                       busy,
    output logic [2:0]                 state_dbg
);

    localparam int CW   = FIFO_ADDR_WIDTH + 1;
    localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [CW-1:0]   FRAME_LEVEL = CW'(FRAME_WORDS);
    localparam logic [10:0]     FRAME_READS = 11'(FRAME_WORDS);
    localparam logic [WD_W-1:0] WD_LAST     = WD_W'(WATCHDOG_CYCLES - 1);

    // Frame size must fit both the 11-bit read counter and the FIFO count width.
    if (FRAME_WORDS < 1 || FRAME_WORDS > 2047 || FRAME_WORDS >= (1 << CW)) begin : g_bad_frame
        $error("led_frame_scheduler: FRAME_WORDS out of range");
    end
    if (WATCHDOG_CYCLES < 1 || DEFAULT_LATCH_TICKS < 0 || DEFAULT_LATCH_TICKS > 65535) begin : g_bad_cfg
        $error("led_frame_scheduler: WATCHDOG_CYCLES or DEFAULT_LATCH_TICKS out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_RELEASE = 3'd2,
        S_SHIFT   = 3'd3,
        S_LATCH   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [23:0]       timer_q;
    logic              pending_q;
    logic [10:0]       rd_cnt_q;
    logic [15:0]       latch_cnt_q;
    logic [WD_W-1:0]   wd_q;

    logic              tick, frame_ready, go_release, in_frame, wd_idle, wd_expire, frame_done;
    logic [CW-1:0]     gated_d;
    logic              frame_start_d, fault_d, busy_d;

    // Shifter contract: it may only start a frame once gated_full_count shows a full frame;
    // fifo_read is one pulse per word and is only honoured in RELEASE/SHIFT.
    always_comb begin
        tick        = cfg_enable && (cfg_frame_period == 24'd0 || timer_q <= 24'd1);
        frame_ready = fifo_full_count >= FRAME_LEVEL;
        go_release  = (state_q == S_WAIT) && cfg_enable && pending_q && frame_ready;
        in_frame    = (state_q == S_RELEASE) || (state_q == S_SHIFT);
        wd_idle     = in_frame && !fifo_read && !string_active;
        wd_expire   = wd_idle && (wd_q == WD_LAST);
        frame_done  = (state_q == S_SHIFT) && (rd_cnt_q == FRAME_READS) && !string_active;
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (cfg_enable) state_d = S_WAIT;
            S_WAIT: begin
                if (!cfg_enable)     state_d = S_IDLE;
                else if (go_release) state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (wd_expire)      state_d = S_LATCH;
                else if (fifo_read) state_d = S_SHIFT;
            end
            S_SHIFT:   if (frame_done || wd_expire) state_d = S_LATCH;
            S_LATCH:   if (latch_cnt_q == 16'd0) state_d = cfg_enable ? S_WAIT : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        frame_start_d = go_release;
        fault_d       = wd_expire;
        busy_d        = in_frame || (state_q == S_LATCH);
        gated_d       = in_frame ? fifo_full_count : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q          <= cfg_frame_period;
            pending_q        <= 1'b0;
            rd_cnt_q         <= '0;
            latch_cnt_q      <= '0;
            wd_q             <= '0;
            frame_count      <= '0;
            underrun_count   <= '0;
            gated_full_count <= '0;
            frame_start      <= 1'b0;
            fault            <= 1'b0;
            busy             <= 1'b0;
        end else begin
            if (!cfg_enable || tick) timer_q <= cfg_frame_period;
            else                     timer_q <= timer_q - 24'd1;

            // A tick landing on the release cycle re-arms pending for the next frame.
            if (!cfg_enable) pending_q <= 1'b0;
            else             pending_q <= tick || (pending_q && !go_release);

            if (tick && pending_q && !go_release && underrun_count != 16'hFFFF)
                underrun_count <= underrun_count + 16'd1;

            if (go_release)
                rd_cnt_q <= '0;
            else if (in_frame && fifo_read && rd_cnt_q != FRAME_READS)
                rd_cnt_q <= rd_cnt_q + 11'd1;

            if (state_d == S_LATCH && state_q != S_LATCH)
                latch_cnt_q <= cfg_latch_ticks;
            else if (state_q == S_LATCH && latch_cnt_q != 16'd0)
                latch_cnt_q <= latch_cnt_q - 16'd1;

            if (wd_idle && !wd_expire) wd_q <= wd_q + 1'b1;
            else                       wd_q <= '0;

            if (frame_done) frame_count <= frame_count + 16'd1;

            gated_full_count <= gated_d;
            frame_start      <= frame_start_d;
            fault            <= fault_d;
            busy             <= busy_d;
        end
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Self-checking bench for led_frame_scheduler: randomized scenarios compared against
// tick/release arithmetic derived from the frame-timing rules.
module tb_led_frame_scheduler;
    localparam int FAW = 12;
    localparam int FW  = 900;
    localparam int WD  = 300;
    localparam int CW  = FAW + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_enable;
    logic [23:0]   cfg_frame_period;
    logic [15:0]   cfg_latch_ticks;
    logic [CW-1:0] fifo_full_count;
    logic          fifo_read;
    logic          string_active;
    logic [CW-1:0] gated_full_count;
    logic          frame_start;
    logic [15:0]   frame_count;
    logic [15:0]   underrun_count;
    logic          fault;
    logic          busy;
    logic [2:0]    state_dbg;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    led_frame_scheduler #(
        .FIFO_ADDR_WIDTH(FAW), .FRAME_WORDS(FW), .WATCHDOG_CYCLES(WD), .DEFAULT_LATCH_TICKS(6000)
    ) dut (
        .clk(clk), .reset(reset), .cfg_enable(cfg_enable), .cfg_frame_period(cfg_frame_period),
        .cfg_latch_ticks(cfg_latch_ticks), .fifo_full_count(fifo_full_count), .fifo_read(fifo_read),
        .string_active(string_active), .gated_full_count(gated_full_count), .frame_start(frame_start),
        .frame_count(frame_count), .underrun_count(underrun_count), .fault(fault), .busy(busy),
        .state_dbg(state_dbg)
    );

    // clock / edge counter / run guard
    always #25 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #(80000 * 50);
        $display("FAIL timeout: got cycle %0d required finish before 80000", cyc);
        $fatal(1, "bench timeout");
    end

    // reference model: ticks fall on edges e0 + k*p - 1 (k >= 1) after enable edge e0
    function automatic int first_tick_from(input int e0, input int p, input int from);
        int t;
        t = e0 + p - 1;
        while (t < from) t = t + p;
        return t;
    endfunction

    function automatic int ticks_in(input int e0, input int p, input int lo, input int hi);
        int n;
        n = 0;
        for (int t = e0 + p - 1; t < hi; t = t + p)
            if (t > lo) n = n + 1;
        return n;
    endfunction

    // driver tasks
    task automatic do_reset();
        reset = 1'b1; cfg_enable = 1'b0; fifo_read = 1'b0; string_active = 1'b0;
        fifo_full_count = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic enable_now(output int e0);
        @(negedge clk);
        cfg_enable = 1'b1;
        @(negedge clk);
        e0 = cyc;
    endtask

    task automatic wait_start(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic shift_words(input int n, input int max_gap);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
            fifo_read = 1'b1;
            @(negedge clk);
            fifo_read = 1'b0;
            fifo_full_count = fifo_full_count - 13'd1;
        end
    endtask

    task automatic finish_frame(output int d);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        string_active = 1'b0;
        d = cyc;
    endtask

    // scenarios
    task automatic test_reset();
        reset = 1'b1; cfg_enable = 1'b0; fifo_read = 1'b0; string_active = 1'b0;
        fifo_full_count = 13'd1000; cfg_frame_period = 24'd1000; cfg_latch_ticks = 16'd100;
        repeat (3) @(negedge clk);
        checks++; if (gated_full_count !== 13'd0) begin failures++; $display("FAIL rst_gated: got %0d expected 0", gated_full_count); end
        checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL rst_frame_start: got %b expected 0", frame_start); end
        checks++; if (frame_count !== 16'd0) begin failures++; $display("FAIL rst_frame_count: got %0d expected 0", frame_count); end
        checks++; if (underrun_count !== 16'd0) begin failures++; $display("FAIL rst_underrun: got %0d expected 0", underrun_count); end
        checks++; if (fault !== 1'b0) begin failures++; $display("FAIL rst_fault: got %b expected 0", fault); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (state_dbg !== 3'd0) begin failures++; $display("FAIL rst_state: got %0d expected 0", state_dbg); end
        reset = 1'b0;
    endtask

    task automatic test_frame();
        int e0, r1, r2, d, x, tf, exp_r2, exp_u;
        do_reset();
        cfg_frame_period = 24'd1000; cfg_latch_ticks = 16'd100; fifo_full_count = 13'd900;
        enable_now(e0);
        wait_start(1100, r1);
        checks++; if (r1 != e0 + 1000) begin failures++; $display("FAIL frame_first_release: got cycle %0d expected %0d", r1, e0 + 1000); end
        checks++; if (gated_full_count !== 13'd0) begin failures++; $display("FAIL frame_gated_lag: got %0d expected 0", gated_full_count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL frame_busy_lag: got %b expected 0", busy); end
        string_active = 1'b1;
        @(negedge clk);
        checks++; if (gated_full_count !== 13'd900) begin failures++; $display("FAIL frame_gated_on: got %0d expected 900", gated_full_count); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL frame_busy_on: got %b expected 1", busy); end
        shift_words(900, 1);
        finish_frame(d);
        checks++; if (frame_count !== 16'd0) begin failures++; $display("FAIL frame_count_before: got %0d expected 0", frame_count); end
        fifo_full_count = 13'd900;
        @(negedge clk);
        x = cyc;
        checks++; if (frame_count !== 16'd1) begin failures++; $display("FAIL frame_count_done: got %0d expected 1", frame_count); end
        checks++; if (state_dbg !== 3'd4) begin failures++; $display("FAIL frame_state_latch: got %0d expected 4", state_dbg); end
        @(negedge clk);
        checks++; if (gated_full_count !== 13'd0) begin failures++; $display("FAIL frame_gated_latch: got %0d expected 0", gated_full_count); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL frame_busy_latch: got %b expected 1", busy); end
        tf     = first_tick_from(e0, 1000, r1);
        exp_r2 = (x + 100 + 2 > tf + 1) ? x + 100 + 2 : tf + 1;
        exp_u  = ticks_in(e0, 1000, tf, exp_r2);
        wait_start(3000, r2);
        checks++; if (r2 != exp_r2) begin failures++; $display("FAIL frame_second_release: got cycle %0d expected %0d", r2, exp_r2); end
        checks++; if (underrun_count !== 16'(exp_u)) begin failures++; $display("FAIL frame_underrun: got %0d expected %0d", underrun_count, exp_u); end
    endtask

    task automatic test_underrun();
        int e0, p, n;
        logic seen;
        do_reset();
        p = $urandom_range(300, 800);
        n = 3 * p + p / 2;
        cfg_frame_period = 24'(p); cfg_latch_ticks = 16'd10;
        fifo_full_count = 13'($urandom_range(0, FW - 1));
        enable_now(e0);
        seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (frame_start === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL ur_no_release: got %b expected 0", seen); end
        checks++; if (underrun_count !== 16'd2) begin failures++; $display("FAIL ur_count: got %0d expected 2", underrun_count); end
        fifo_full_count = 13'd900;
        @(negedge clk);
        checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL ur_release_on_fill: got %b expected 1", frame_start); end
    endtask

    task automatic test_period_zero();
        int e0, m;
        do_reset();
        cfg_frame_period = 24'd0; cfg_latch_ticks = 16'd0; fifo_full_count = 13'd0;
        enable_now(e0);
        m = $urandom_range(5, 40);
        repeat (m) @(negedge clk);
        checks++; if (underrun_count !== 16'(m)) begin failures++; $display("FAIL p0_underrun: got %0d expected %0d", underrun_count, m); end
        fifo_full_count = 13'd900;
        @(negedge clk);
        checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL p0_release: got %b expected 1", frame_start); end
        checks++; if (underrun_count !== 16'(m)) begin failures++; $display("FAIL p0_no_underrun_on_release: got %0d expected %0d", underrun_count, m); end
        @(negedge clk);
        checks++; if (underrun_count !== 16'(m + 1)) begin failures++; $display("FAIL p0_pending_kept: got %0d expected %0d", underrun_count, m + 1); end
    endtask

    task automatic test_one_and_half();
        int e0, p, r1, d, tf, rr, exp_u;
        logic seen;
        do_reset();
        p = $urandom_range(400, 900);
        cfg_frame_period = 24'(p); cfg_latch_ticks = 16'($urandom_range(0, 50));
        fifo_full_count = 13'd1350;
        enable_now(e0);
        wait_start(p + 10, r1);
        checks++; if (r1 != e0 + p) begin failures++; $display("FAIL oh_release: got cycle %0d expected %0d", r1, e0 + p); end
        string_active = 1'b1;
        @(negedge clk);
        checks++; if (gated_full_count !== 13'd1350) begin failures++; $display("FAIL oh_gated_on: got %0d expected 1350", gated_full_count); end
        shift_words(900, 1);
        finish_frame(d);
        @(negedge clk);
        checks++; if (frame_count !== 16'd1) begin failures++; $display("FAIL oh_frame_count: got %0d expected 1", frame_count); end
        @(negedge clk);
        checks++; if (gated_full_count !== 13'd0) begin failures++; $display("FAIL oh_gated_latch: got %0d expected 0", gated_full_count); end
        seen = 1'b0;
        repeat (2 * p) begin
            @(negedge clk);
            if (frame_start === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL oh_single_frame: got %b expected 0", seen); end
        fifo_full_count = 13'd900;
        rr = cyc + 1;
        @(negedge clk);
        checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL oh_refill_release: got %b expected 1", frame_start); end
        tf    = first_tick_from(e0, p, r1);
        exp_u = ticks_in(e0, p, tf, rr);
        checks++; if (underrun_count !== 16'(exp_u)) begin failures++; $display("FAIL oh_underrun: got %0d expected %0d", underrun_count, exp_u); end
    endtask

    task automatic test_watchdog();
        int e0, p, r1, n;
        logic seen, seen2;
        do_reset();
        p = $urandom_range(100, 300);
        cfg_frame_period = 24'(p); cfg_latch_ticks = 16'($urandom_range(0, 20));
        fifo_full_count = 13'd900;
        enable_now(e0);
        wait_start(p + 10, r1);
        string_active = 1'b1;
        @(negedge clk);
        shift_words(10, 2);
        string_active = 1'b0;
        n = cyc;
        seen = 1'b0;
        repeat (WD - 1) begin
            @(negedge clk);
            if (fault === 1'b1) seen = 1'b1;
        end
        fifo_read = 1'b1;
        @(negedge clk);
        checks++; if (seen !== 1'b0 || fault !== 1'b0) begin failures++; $display("FAIL wd_read_wins: got fault %b/%b expected 0/0", seen, fault); end
        fifo_read = 1'b0;
        fifo_full_count = fifo_full_count - 13'd1;
        seen2 = 1'b0;
        repeat (WD - 1) begin
            @(negedge clk);
            if (fault === 1'b1) seen2 = 1'b1;
        end
        @(negedge clk);
        checks++; if (seen2 !== 1'b0) begin failures++; $display("FAIL wd_no_early: got %b expected 0", seen2); end
        checks++; if (fault !== 1'b1) begin failures++; $display("FAIL wd_fault: got %b expected 1 at cycle %0d", fault, n + 2 * WD); end
        checks++; if (state_dbg !== 3'd4) begin failures++; $display("FAIL wd_latch: got %0d expected 4", state_dbg); end
        @(negedge clk);
        checks++; if (fault !== 1'b0) begin failures++; $display("FAIL wd_pulse: got %b expected 0", fault); end
        checks++; if (frame_count !== 16'd0) begin failures++; $display("FAIL wd_no_count: got %0d expected 0", frame_count); end
    endtask

    task automatic test_enable_drop();
        int e0, e0b, p, l, r1, r, d;
        do_reset();
        p = $urandom_range(1000, 1400);
        l = $urandom_range(5, 30);
        cfg_frame_period = 24'(p); cfg_latch_ticks = 16'(l); fifo_full_count = 13'd900;
        enable_now(e0);
        wait_start(p + 10, r1);
        checks++; if (r1 != e0 + p) begin failures++; $display("FAIL en_release: got cycle %0d expected %0d", r1, e0 + p); end
        string_active = 1'b1;
        @(negedge clk);
        shift_words(450, 1);
        cfg_enable = 1'b0;
        shift_words(450, 1);
        finish_frame(d);
        @(negedge clk);
        checks++; if (frame_count !== 16'd1) begin failures++; $display("FAIL en_frame_count: got %0d expected 1", frame_count); end
        repeat (l + 2) @(negedge clk);
        checks++; if (state_dbg !== 3'd0) begin failures++; $display("FAIL en_idle: got %0d expected 0", state_dbg); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL en_busy_low: got %b expected 0", busy); end
        checks++; if (underrun_count !== 16'd0) begin failures++; $display("FAIL en_no_underrun: got %0d expected 0", underrun_count); end
        repeat ($urandom_range(10, 200)) @(negedge clk);
        fifo_full_count = 13'd900;
        enable_now(e0b);
        wait_start(p + 10, r);
        checks++; if (r != e0b + p) begin failures++; $display("FAIL en_timer_held: got cycle %0d expected %0d", r, e0b + p); end
    endtask

    task automatic test_reset_mid();
        int e0, p, r;
        do_reset();
        p = $urandom_range(100, 300);
        cfg_frame_period = 24'(p); cfg_latch_ticks = 16'd20; fifo_full_count = 13'd900;
        enable_now(e0);
        wait_start(p + 10, r);
        string_active = 1'b1;
        @(negedge clk);
        shift_words(50, 1);
        fifo_read = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (gated_full_count !== 13'd0) begin failures++; $display("FAIL mid_gated: got %0d expected 0", gated_full_count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy: got %b expected 0", busy); end
        checks++; if (state_dbg !== 3'd0) begin failures++; $display("FAIL mid_state: got %0d expected 0", state_dbg); end
        checks++; if (frame_start !== 1'b0 || fault !== 1'b0) begin failures++; $display("FAIL mid_pulses: got %b/%b expected 0/0", frame_start, fault); end
        checks++; if (frame_count !== 16'd0 || underrun_count !== 16'd0) begin failures++; $display("FAIL mid_counts: got %0d/%0d expected 0/0", frame_count, underrun_count); end
        fifo_read = 1'b0; string_active = 1'b0; cfg_enable = 1'b0;
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_frame();
        test_underrun();
        test_period_zero();
        test_one_and_half();
        test_watchdog();
        test_enable_drop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
